// File: rtl/ram_arb_if.sv
// ram_arb_if: one request/response bus between a bus master and a memory port.
//   stb    master -> slave  request strobe, held for the whole transaction
//   we     master -> slave  write enable
//   addr   master -> slave  25-bit word address [26:2]
//   wdata  master -> slave  write data
//   rdata  slave -> master  read data
//   ack    slave -> master  completion pulse
//   err    slave -> master  timeout pulse (not produced by the ram itself)
interface ram_arb_if;
    logic        stb;
    logic        we;
    logic [24:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;
    logic        err;

    modport master (
        output stb, we, addr, wdata,
        input  rdata, ack, err
    );

    modport slave (
        input  stb, we, addr, wdata,
        output rdata, ack, err
    );
endinterface

// File: rtl/ram_arb.sv
// ram_arb: round-robin arbiter sharing one ram port between two masters
// (m0 = CPU bus, m1 = DMA/video fetch). One transaction at a time,
// IDLE -> BUSY -> RESP -> IDLE; all outputs are registered.
// Ports:
//   clk, rst_n   ram-domain clock, asynchronous active-low reset
//   m0, m1       ram_arb_if.slave   master request buses
//                (stb/we/addr/wdata in, rdata/ack/err out)
//   s            ram_arb_if.master  ram port (stb/we/addr/wdata out, rdata/ack in)
// Parameters:
//   TIMEOUT_CYCLES  BUSY cycles without s.ack before abort
//   TO_W            timeout counter width (TIMEOUT_CYCLES < 2**TO_W)
// Optional feature: define RAM_ARB_TIMEOUT_EN to enable the BUSY timeout;
// without it BUSY waits forever and m0.err/m1.err are constant 0.
module ram_arb #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_W           = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    ram_arb_if.slave   m0,
    ram_arb_if.slave   m1,
    ram_arb_if.master  s
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    logic   owner;
    logic   last;
    logic   grant;

`ifdef RAM_ARB_TIMEOUT_EN
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0] to_cnt;
`else
    assign m0.err = 1'b0;
    assign m1.err = 1'b0;
`endif

    // On a tie the master that was not served last wins; last resets to 1
    // so m0 takes the first tie.
    always_comb begin
        grant = 1'b0;
        if (m0.stb && m1.stb) begin
            grant = ~last;
        end else begin
            grant = m1.stb;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            owner    <= 1'b0;
            last     <= 1'b1;
            s.stb    <= 1'b0;
            s.we     <= 1'b0;
            s.addr   <= '0;
            s.wdata  <= '0;
            m0.rdata <= '0;
            m1.rdata <= '0;
            m0.ack   <= 1'b0;
            m1.ack   <= 1'b0;
`ifdef RAM_ARB_TIMEOUT_EN
            m0.err   <= 1'b0;
            m1.err   <= 1'b0;
            to_cnt   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (m0.stb || m1.stb) begin
                        owner   <= grant;
                        s.stb   <= 1'b1;
                        s.we    <= grant ? m1.we    : m0.we;
                        s.addr  <= grant ? m1.addr  : m0.addr;
                        s.wdata <= grant ? m1.wdata : m0.wdata;
                        state   <= BUSY;
`ifdef RAM_ARB_TIMEOUT_EN
                        to_cnt  <= '0;
`endif
                    end
                end
                BUSY: begin
                    // Master inputs are not looked at here; the slave fields
                    // stay as latched in IDLE until the ram answers.
                    if (s.ack) begin
                        s.stb <= 1'b0;
                        last  <= owner;
                        state <= RESP;
                        if (owner) begin
                            m1.ack <= 1'b1;
                            if (!s.we) m1.rdata <= s.rdata;
                        end else begin
                            m0.ack <= 1'b1;
                            if (!s.we) m0.rdata <= s.rdata;
                        end
                    end
`ifdef RAM_ARB_TIMEOUT_EN
                    // A real ack on the final counted cycle takes priority
                    // over the abort (handled by the branch above).
                    else if (to_cnt == TO_LAST) begin
                        s.stb <= 1'b0;
                        last  <= owner;
                        state <= RESP;
                        if (owner) m1.err <= 1'b1;
                        else       m0.err <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
`endif
                end
                RESP: begin
                    // Requests still held here are the finished ones, so
                    // nothing is sampled until IDLE.
                    m0.ack <= 1'b0;
                    m1.ack <= 1'b0;
`ifdef RAM_ARB_TIMEOUT_EN
                    m0.err <= 1'b0;
                    m1.err <= 1'b0;
`endif
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arb.sv
module tb_ram_arb;

    localparam int TIMEOUT = 16;
    localparam int MODE_OK   = 0;
    localparam int MODE_ERR  = 1;
    localparam int MODE_NONE = 2;

    typedef struct {
        logic        we;
        logic [24:0] addr;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        logic        we;
        logic [24:0] addr;
        logic [31:0] wdata;
        int          lat;
    } slave_exp_t;

    typedef struct {
        int          master;
        logic        isErr;
        logic        isRead;
        logic [31:0] data;
    } resp_exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic modelAck = 1'b0;
    logic injectAck = 1'b0;
    logic [31:0] modelRdata = '0;

    int testCount = 0;
    int failCount = 0;

    req_t       reqQ0[$];
    req_t       reqQ1[$];
    slave_exp_t slaveQ[$];
    resp_exp_t  respQ[$];

    logic [31:0] refMem[logic [24:0]];
    logic [31:0] ramMem[logic [24:0]];

    ram_arb_if m0Bus();
    ram_arb_if m1Bus();
    ram_arb_if sBus();

    assign sBus.ack   = modelAck | injectAck;
    assign sBus.rdata = modelRdata;
    assign sBus.err   = 1'b0;

    ram_arb #(.TIMEOUT_CYCLES(TIMEOUT), .TO_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .m0    (m0Bus),
        .m1    (m1Bus),
        .s     (sBus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] defaultWord(input logic [24:0] a);
        return {a[6:0], a} ^ 32'h5A5A_5A5A;
    endfunction

    function automatic logic [31:0] refRead(input logic [24:0] a);
        if (refMem.exists(a)) return refMem[a];
        return defaultWord(a);
    endfunction

    // Queue one master transaction and record what the ram port and the
    // master should see for it.
    task automatic applyStimulus(input int master, input logic we,
                                 input logic [24:0] addr, input logic [31:0] wdata,
                                 input int lat, input int mode);
        req_t       r;
        slave_exp_t se;
        resp_exp_t  re;
        r.we = we; r.addr = addr; r.wdata = wdata;
        se.we = we; se.addr = addr; se.wdata = wdata; se.lat = lat;
        slaveQ.push_back(se);
        if (mode != MODE_NONE) begin
            re.master = master;
            re.isErr  = (mode == MODE_ERR);
            re.isRead = !we;
            re.data   = we ? 32'h0 : refRead(addr);
            respQ.push_back(re);
            if (we && mode == MODE_OK) refMem[addr] = wdata;
        end
        if (master == 0) reqQ0.push_back(r);
        else             reqQ1.push_back(r);
    endtask

    task automatic checkResp(input int m, input logic ack, input logic err,
                             input logic [31:0] data);
        resp_exp_t r;
        if (ack || err) begin
            if (respQ.size() == 0) begin
                checkOutput("unexpected response", {31'd0, ack | err}, 32'd0);
            end else begin
                r = respQ.pop_front();
                checkOutput("resp master", m, r.master);
                checkOutput("resp err", {31'd0, err}, {31'd0, r.isErr});
                checkOutput("resp ack", {31'd0, ack}, {31'd0, !r.isErr});
                if (r.isRead && !r.isErr) checkOutput("read data", data, r.data);
            end
        end
    endtask

    task automatic waitDrain(input int budget);
        int n = 0;
        while ((respQ.size() != 0 || slaveQ.size() != 0 || reqQ0.size() != 0 ||
                reqQ1.size() != 0 || m0Bus.stb || m1Bus.stb || sBus.stb) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) checkOutput("drain timeout", n, 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic waitSlaveStb(input int budget);
        int n = 0;
        while (!sBus.stb && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!sBus.stb) checkOutput("wait s_stb", {31'd0, sBus.stb}, 32'd1);
    endtask

    // Master behaviour: hold stb until ack/err, drop it the cycle after,
    // then raise the next queued request.
    always @(negedge clk) begin
        req_t r;
        if (!rst_n) begin
            m0Bus.stb = 1'b0;
            m1Bus.stb = 1'b0;
            reqQ0.delete();
            reqQ1.delete();
        end else begin
            if (m0Bus.ack || m0Bus.err) m0Bus.stb = 1'b0;
            else if (!m0Bus.stb && reqQ0.size() != 0) begin
                r = reqQ0.pop_front();
                m0Bus.we = r.we; m0Bus.addr = r.addr; m0Bus.wdata = r.wdata;
                m0Bus.stb = 1'b1;
            end
            if (m1Bus.ack || m1Bus.err) m1Bus.stb = 1'b0;
            else if (!m1Bus.stb && reqQ1.size() != 0) begin
                r = reqQ1.pop_front();
                m1Bus.we = r.we; m1Bus.addr = r.addr; m1Bus.wdata = r.wdata;
                m1Bus.stb = 1'b1;
            end
        end
    end

    // Ram model and slave-side scoreboard. lat N acks on the N-th cycle of
    // s_stb; lat 0 never acks.
    int   curLat = 0;
    int   latCnt = 0;
    int   stbCnt = 0;
    int   stbExp = 0;
    logic prevStb = 1'b0;
    always @(negedge clk) begin
        slave_exp_t e;
        modelAck = 1'b0;
        if (sBus.stb && !prevStb) begin
            if (slaveQ.size() == 0) begin
                checkOutput("unexpected s_stb", 32'd1, 32'd0);
                curLat = 1;
                stbExp = 1;
            end else begin
                e = slaveQ.pop_front();
                checkOutput("s_addr", {7'd0, sBus.addr}, {7'd0, e.addr});
                checkOutput("s_we", {31'd0, sBus.we}, {31'd0, e.we});
                if (e.we) checkOutput("s_data_out", sBus.wdata, e.wdata);
                curLat = e.lat;
                stbExp = (e.lat == 0) ? TIMEOUT : e.lat;
            end
            stbCnt = 0;
            latCnt = 0;
        end
        if (!sBus.stb && prevStb && rst_n) checkOutput("s_stb width", stbCnt, stbExp);
        if (sBus.stb) begin
            stbCnt++;
            latCnt++;
            if (curLat > 0 && latCnt == curLat) begin
                modelAck = 1'b1;
                if (sBus.we) ramMem[sBus.addr] = sBus.wdata;
                else modelRdata = ramMem.exists(sBus.addr) ? ramMem[sBus.addr]
                                                           : defaultWord(sBus.addr);
            end
        end
        prevStb = sBus.stb;
    end

    // Master-side scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            checkResp(0, m0Bus.ack, m0Bus.err, m0Bus.rdata);
            checkResp(1, m1Bus.ack, m1Bus.err, m1Bus.rdata);
        end
    end

    task automatic resetDut();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        m0Bus.stb = 0; m0Bus.we = 0; m0Bus.addr = '0; m0Bus.wdata = '0;
        m1Bus.stb = 0; m1Bus.we = 0; m1Bus.addr = '0; m1Bus.wdata = '0;
        refMem[25'h0000100] = 32'hDEADBEEF;
        ramMem[25'h0000100] = 32'hDEADBEEF;

        resetDut();
        checkOutput("reset s_stb", {31'd0, sBus.stb}, 32'd0);
        checkOutput("reset s_we", {31'd0, sBus.we}, 32'd0);
        checkOutput("reset s_addr", {7'd0, sBus.addr}, 32'd0);
        checkOutput("reset s_data_out", sBus.wdata, 32'd0);
        checkOutput("reset m0_ack", {31'd0, m0Bus.ack}, 32'd0);
        checkOutput("reset m1_ack", {31'd0, m1Bus.ack}, 32'd0);
        checkOutput("reset m0_err", {31'd0, m0Bus.err}, 32'd0);
        checkOutput("reset m1_err", {31'd0, m1Bus.err}, 32'd0);
        checkOutput("reset m0_data_out", m0Bus.rdata, 32'd0);

        // Single read from m0, ram answers after 3 cycles.
        applyStimulus(0, 1'b0, 25'h0000100, 32'h0, 3, MODE_OK);
        waitDrain(200);

        // Single write from m1 to the top address.
        applyStimulus(1, 1'b1, 25'h1FFFFFF, 32'h12345678, 2, MODE_OK);
        waitDrain(200);
        checkOutput("m0 data_out holds", m0Bus.rdata, 32'hDEADBEEF);

        // Reset in the middle of a BUSY transaction.
        applyStimulus(0, 1'b0, 25'h0000055, 32'h0, 0, MODE_NONE);
        waitSlaveStb(50);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async reset s_stb", {31'd0, sBus.stb}, 32'd0);
        checkOutput("async reset m0_ack", {31'd0, m0Bus.ack}, 32'd0);
        checkOutput("async reset m1_ack", {31'd0, m1Bus.ack}, 32'd0);
        checkOutput("async reset m0_err", {31'd0, m0Bus.err}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        injectAck = 1'b1;
        @(negedge clk);
        injectAck = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("late ack ignored s_stb", {31'd0, sBus.stb}, 32'd0);
        end

        // Both masters requesting continuously from reset: strict alternation,
        // m1 reads back what m0 just wrote.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1'b1, 25'h0000200 + 25'(i), 32'hA000_0000 + 32'(i), 1 + (i % 3), MODE_OK);
            applyStimulus(1, 1'b0, 25'h0000200 + 25'(i), 32'h0, 1 + ((i + 1) % 3), MODE_OK);
        end
        waitDrain(500);

`ifdef RAM_ARB_TIMEOUT_EN
        // Ram never answers m0: abort after TIMEOUT busy cycles, then m1.
        applyStimulus(0, 1'b0, 25'h0000300, 32'h0, 0, MODE_ERR);
        waitSlaveStb(50);
        applyStimulus(1, 1'b1, 25'h0000301, 32'hCAFE_F00D, 2, MODE_OK);
        waitDrain(500);

        // Ack on the last counted busy cycle beats the timeout.
        applyStimulus(0, 1'b0, 25'h0000100, 32'h0, TIMEOUT, MODE_OK);
        waitDrain(500);
`endif

        checkOutput("scoreboard empty", respQ.size() + slaveQ.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
